// File: rtl/hex_keypad_pkg.sv
// hex_keypad_pkg: shared types, column strobes and keymap for the hex keypad scanner
package hex_keypad_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DEB_PRESS, ST_PRESSED, ST_DEB_REL} state_e;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} result_e;
  localparam logic [3:0] COL0_STROBE = 4'b0111;
  localparam logic [3:0] COL1_STROBE = 4'b1011;
  localparam logic [3:0] COL2_STROBE = 4'b1101;
  localparam logic [3:0] COL3_STROBE = 4'b1110;
  // Nibbles in reading order: row0 col0 is the top nibble, row3 col3 the bottom one.
  localparam logic [63:0] KEYMAP = 64'h123A_456B_789C_E0FD;
  function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{~row, ~col, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/hex_keypad_scan_frame_sampler.sv
// keypad_frame_sampler: scans columns, synchronises rows and classifies each full frame
module keypad_frame_sampler import hex_keypad_pkg::*; #(
  parameter int SCAN_W = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic       frame_done,
  output result_e    res,
  output logic [3:0] code
);
  logic [SCAN_W-1:0] cnt_q;
  logic [3:0] sync1_q, sync2_q;
  logic [15:0] acc_q, acc_d;
  logic frame_done_q;
  logic [1:0] col;
  logic sample;
  logic [4:0] n;
  logic [3:0] idx;
  assign col = cnt_q[SCAN_W-1 -: 2];
  assign sample = &cnt_q[SCAN_W-3:0];
  assign frame_done = frame_done_q;
  assign col_drive = col == 2'd0 ? COL0_STROBE : col == 2'd1 ? COL1_STROBE :
                     col == 2'd2 ? COL2_STROBE : COL3_STROBE;
  // Accumulator bit {row,col} holds the active-low row level; idle frames read all ones.
  always_comb begin
    acc_d = frame_done_q ? '1 : acc_q;
    for (int r = 0; r < 4; r++) if (sample) acc_d[{2'(r), col}] = sync2_q[r];
  end
  // Count pressed positions and remember the one found, to classify the finished frame.
  always_comb begin
    n = 5'd0;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) if (!acc_q[4'(i)]) begin
      n = n + 5'd1;
      idx = 4'(i);
    end
    res = n == 5'd0 ? RES_NONE : n == 5'd1 ? RES_SINGLE : RES_MULTI;
    code = map_key(idx[3:2], idx[1:0]);
  end
  // Scan counter, two-flop row synchroniser, accumulator and end-of-frame strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sync1_q <= '1;
      sync2_q <= '1;
      acc_q <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      sync1_q <= row_in;
      sync2_q <= sync1_q;
      acc_q <= acc_d;
      frame_done_q <= &cnt_q;
    end
  end
endmodule

// File: rtl/hex_keypad_scan.sv
// hex_keypad_scan: debounced 4x4 keypad scanner with press pulse and 4-digit entry register
module hex_keypad_scan import hex_keypad_pkg::*; #(
  parameter int SCAN_W = 10,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  input  logic        clr,
  output logic [3:0]  col_drive,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] entered_number
);
  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);
  state_e state_q, state_d;
  result_e res;
  logic frame_done, accept;
  logic [3:0] code, cand_q, cand_d, cnt_q, cnt_d, cnt_inc, code_q, code_d;
  logic valid_q, valid_d;
  logic [15:0] num_q, num_d;
  keypad_frame_sampler #(.SCAN_W(SCAN_W)) u_sampler (
    .clk(clk),
    .rst_n(rst_n),
    .row_in(row_in),
    .col_drive(col_drive),
    .frame_done(frame_done),
    .res(res),
    .code(code)
  );
  assign cnt_inc = cnt_q + 4'd1;
  // Debounce FSM advances once per frame; accept fires on the frame that completes a press.
  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    accept = 1'b0;
    if (frame_done) case (state_q)
      ST_IDLE: if (res == RES_SINGLE) begin
        cand_d = code;
        cnt_d = 4'd1;
        accept = DF == 4'd1;
        state_d = accept ? ST_PRESSED : ST_DEB_PRESS;
      end
      ST_DEB_PRESS: if (res == RES_SINGLE && code == cand_q) begin
        cnt_d = cnt_inc;
        accept = cnt_inc == DF;
        state_d = accept ? ST_PRESSED : ST_DEB_PRESS;
      end else state_d = ST_IDLE;
      ST_PRESSED: if (res == RES_NONE) begin
        cnt_d = 4'd1;
        state_d = DF == 4'd1 ? ST_IDLE : ST_DEB_REL;
      end
      ST_DEB_REL: if (res == RES_NONE) begin
        cnt_d = cnt_inc;
        state_d = cnt_inc == DF ? ST_IDLE : ST_DEB_REL;
      end else state_d = ST_PRESSED;
      default: state_d = ST_IDLE;
    endcase
    valid_d = accept;
    code_d = accept ? cand_d : code_q;
    num_d = clr ? 16'h0000 : accept ? {num_q[11:0], cand_d} : num_q;
  end
  // State, debounce count and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cand_q <= 4'd0;
      cnt_q <= 4'd0;
      code_q <= 4'd0;
      valid_q <= 1'b0;
      num_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      code_q <= code_d;
      valid_q <= valid_d;
      num_q <= num_d;
    end
  end
  assign key_code = code_q;
  assign key_valid = valid_q;
  assign key_held = state_q == ST_PRESSED || state_q == ST_DEB_REL;
  assign entered_number = num_q;
endmodule

// File: tb/tb_hex_keypad_scan.sv
// tb_hex_keypad_scan: frame-level random and directed checks against a press/release model
module tb_hex_keypad_scan;
  localparam int SW = 6;
  localparam int DF = 4;
  localparam int SLOT = 1 << (SW - 2);
  localparam int FRAME = 1 << SW;
  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
  logic [3:0] row_in, col_drive, key_code;
  logic key_valid, key_held;
  logic [15:0] entered_number;
  logic [15:0] pressed = '0;
  logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                          4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  int pass_n = 0, total_n = 0, t = 0, seen = 0, mark;
  bit m_held, m_accept, prev_ok;
  int m_run, m_rel, m_pulses;
  logic [3:0] m_run_code, m_code, exp_col;
  logic [15:0] m_num, prev, cur;

  hex_keypad_scan #(.SCAN_W(SW), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row_in(row_in),
    .clr(clr),
    .col_drive(col_drive),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held),
    .entered_number(entered_number)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) t <= !rst_n ? 0 : t + 1;

  always @(negedge clk) if (rst_n && key_valid) seen++;

  // Physical keypad: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row_in = 4'b1111;
    for (int c = 0; c < 4; c++)
      if (col_drive == 4'(~(4'b1000 >> c)))
        for (int r = 0; r < 4; r++) if (pressed[r * 4 + c]) row_in[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] kb(input logic [3:0] code);
    kb = '0;
    for (int i = 0; i < 16; i++) if (km[i] == code) kb[i] = 1'b1;
  endfunction

  // A press counts once DF frames in a row show the same lone key, starting from a
  // frame that began the run; a release needs DF empty frames in a row.
  task automatic model_eval(input logic [15:0] k, input bit c);
    int n;
    logic [3:0] code;
    n = $countones(k);
    code = 4'h0;
    for (int i = 0; i < 16; i++) if (k[i]) code = km[i];
    m_accept = 1'b0;
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0 && code != m_run_code) m_run = 0;
        else begin
          if (m_run == 0) m_run_code = code;
          m_run++;
        end
      end else m_run = 0;
      if (m_run == DF) begin
        m_accept = 1'b1;
        m_held = 1'b1;
        m_run = 0;
        m_rel = 0;
      end
    end else begin
      m_rel = n == 0 ? m_rel + 1 : 0;
      if (m_rel == DF) begin
        m_held = 1'b0;
        m_rel = 0;
      end
    end
    if (m_accept) begin
      m_code = m_run_code;
      m_pulses++;
      m_num = {m_num[11:0], m_run_code};
    end
    if (c) m_num = 16'h0000;
  endtask

  // One scan frame with key set k; its first edge evaluates the previous frame, where c is the clear.
  task automatic do_frame(input logic [15:0] k, input bit c = 1'b0);
    pressed = k;
    clr = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
    if (prev_ok) begin
      model_eval(prev, c);
      chk("key_valid", 32'(key_valid), 32'(m_accept));
      chk("key_code", 32'(key_code), 32'(m_code));
      chk("entered_number", 32'(entered_number), 32'(m_num));
      chk("key_held", 32'(key_held), 32'(m_held));
    end
    prev = k;
    prev_ok = 1'b1;
    for (int i = 1; i < FRAME; i++) begin
      @(posedge clk);
      #1;
      if (i % SLOT == SLOT / 2) begin
        exp_col = ~(4'b1000 >> ((t / SLOT) % 4));
        chk("col_drive", 32'(col_drive), 32'(exp_col));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pressed = '0;
    #1;
    chk("rst key_valid", 32'(key_valid), 32'd0);
    chk("rst key_held", 32'(key_held), 32'd0);
    chk("rst key_code", 32'(key_code), 32'd0);
    chk("rst entered_number", 32'(entered_number), 32'd0);
    chk("rst col_drive", 32'(col_drive), 32'b0111);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_held = 1'b0;
    m_run = 0;
    m_rel = 0;
    m_code = 4'h0;
    m_num = 16'h0000;
    prev_ok = 1'b0;
  endtask

  task automatic press(input logic [3:0] code);
    repeat (DF) do_frame(kb(code));
    repeat (DF) do_frame('0);
  endtask

  initial begin
    m_pulses = 0;
    #2;
    do_reset();
    repeat (3) do_frame('0);
    press(4'h6);
    do_frame('0);
    do_frame('0, 1'b1);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'hA);
    chk("digits 123A", 32'(entered_number), 32'h123A);
    press(4'h5);
    chk("digits 23A5", 32'(entered_number), 32'h23A5);
    mark = seen;
    repeat (2) do_frame(kb(4'h9));
    do_frame('0);
    repeat (4) do_frame(kb(4'h9));
    repeat (DF + 1) do_frame('0);
    chk("bounce pulses", 32'(seen - mark), 32'd1);
    mark = seen;
    repeat (5) do_frame(kb(4'h1) | kb(4'h2));
    repeat (2) do_frame('0);
    chk("multi pulses", 32'(seen - mark), 32'd0);
    mark = seen;
    repeat (DF) do_frame(kb(4'h3));
    repeat (2) do_frame('0);
    do_frame(kb(4'h3));
    chk("rebounce held", 32'(key_held), 32'd1);
    do_frame(kb(4'h3));
    repeat (DF + 1) do_frame('0);
    chk("rebounce pulses", 32'(seen - mark), 32'd1);
    do_frame('0, 1'b1);
    press(4'h1);
    press(4'h2);
    chk("pre-clr number", 32'(entered_number), 32'h0012);
    repeat (DF) do_frame(kb(4'h7));
    do_frame('0, 1'b1);
    chk("clr wins number", 32'(entered_number), 32'h0000);
    chk("clr key_code", 32'(key_code), 32'h7);
    repeat (DF) do_frame('0);
    press(4'h8);
    repeat (3) do_frame(kb(4'h5));
    mark = seen;
    do_reset();
    repeat (DF + 2) do_frame('0);
    chk("no pulse after reset", 32'(seen - mark), 32'd0);
    cur = '0;
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 99) >= 70) begin
        int s;
        s = $urandom_range(0, 99);
        cur = s < 40 ? 16'h0000 : s < 85 ? 16'h0001 << $urandom_range(0, 15) :
              (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      end
      do_frame(cur, $urandom_range(0, 19) == 0);
    end
    repeat (DF + 1) do_frame('0);
    chk("total pulses", 32'(seen), 32'(m_pulses));
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
